// File: rtl/spi_xfer_sched_if.sv
// spi_xfer_sched_if: Wishbone link between the transfer scheduler and the
// wb2spi bridge slave port.
//   wb_cyc/wb_stb   cycle and strobe (always equal)
//   wb_addr         register select: 00 SPCR, 01 SPSR, 10 SPDR
//   wb_we           write enable
//   wb_data_out     write data toward the bridge
//   wb_data_in      read data from the bridge
//   wb_ack          bridge acknowledge
interface spi_xfer_sched_if;
  logic       wb_cyc;
  logic       wb_stb;
  logic [1:0] wb_addr;
  logic       wb_we;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in;
  logic       wb_ack;

  modport master (output wb_cyc, wb_stb, wb_addr, wb_we, wb_data_out,
                  input  wb_data_in, wb_ack);
  modport slave  (input  wb_cyc, wb_stb, wb_addr, wb_we, wb_data_out,
                  output wb_data_in, wb_ack);
endinterface

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: shares one wb2spi bridge among NREQ byte-transfer clients.
// After reset it writes cfg_spcr to SPCR once, then grants requesters
// round-robin. Each grant runs: write TX byte to SPDR, wait START_WAIT cycles,
// poll SPSR bit 0 until clear (or TIMEOUT polls), read SPDR, respond.
//   wb_clk, wb_rst        clock, asynchronous active-low reset
//   cfg_spcr              SPCR value written after reset
//   req_valid/req_data    per-requester request, byte i at [8i+7:8i]
//   req_ready             one-hot grant pulse (accept)
//   rsp_valid             one-hot response pulse
//   rsp_data/rsp_err      RX byte / timeout flag, held between pulses
//   busy                  high whenever not idle
//   wb                    Wishbone master toward the bridge
module spi_xfer_sched #(
  parameter int NREQ       = 4,
  parameter int START_WAIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [7:0]          cfg_spcr,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                rsp_err,
  output logic                busy,
  spi_xfer_sched_if.master    wb
);
  localparam int PW   = $clog2(NREQ);
  localparam int CMAX = (TIMEOUT > START_WAIT) ? TIMEOUT : START_WAIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [1:0] A_SPCR = 2'b00, A_SPSR = 2'b01, A_SPDR = 2'b10;

  typedef enum logic [2:0] {
    S_INIT_WR, S_IDLE, S_WR_DATA, S_WAIT_START, S_POLL, S_RD_DATA, S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic            cyc_q, cyc_d, we_q, we_d, err_q, err_d, busy_q, busy_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      dout_q, dout_d, tx_q, tx_d, rdat_q, rdat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d, sel_q, sel_d;

  // Round-robin pick: first asserted request after the last one served.
  logic            gnt_any;
  logic [PW-1:0]   gnt_sel;
  logic [7:0]      gnt_byte;
  int              j;
  always_comb begin
    gnt_any  = 1'b0;
    gnt_sel  = '0;
    gnt_byte = '0;
    j        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && ((req_valid >> j) & ONE) != '0) begin
        gnt_any  = 1'b1;
        gnt_sel  = PW'(j);
        gnt_byte = 8'(req_data >> (8 * j));
      end
    end
  end

  // Bus access wanted by the current state. An access is raised only from an
  // idle bus and dropped at the ack edge, so consecutive accesses always
  // have one idle cycle between them.
  logic       acc_req, acc_we, acc_done;
  logic [1:0] acc_addr;
  logic [7:0] acc_wdat;
  always_comb begin
    acc_req  = 1'b0;
    acc_addr = A_SPCR;
    acc_we   = 1'b0;
    acc_wdat = '0;
    case (state_q)
      S_INIT_WR: begin acc_req = 1'b1; acc_we = 1'b1; acc_wdat = cfg_spcr; end
      S_WR_DATA: begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = A_SPDR; acc_wdat = tx_q; end
      S_POLL:    begin acc_req = 1'b1; acc_addr = A_SPSR; end
      S_RD_DATA: begin acc_req = 1'b1; acc_addr = A_SPDR; end
      default: ;
    endcase
    acc_done = cyc_q & wb.wb_ack;
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    addr_d    = addr_q;
    we_d      = we_q;
    dout_d    = dout_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    tx_d      = tx_q;
    rdat_d    = rdat_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;

    if (acc_req && !cyc_q) begin
      cyc_d  = 1'b1;
      addr_d = acc_addr;
      we_d   = acc_we;
      dout_d = acc_wdat;
    end else if (acc_done) begin
      cyc_d  = 1'b0;
      we_d   = 1'b0;
      dout_d = '0;
    end

    case (state_q)
      S_INIT_WR: if (acc_done) state_d = S_IDLE;
      S_IDLE: if (gnt_any) begin
        req_ready = ONE << gnt_sel;
        sel_d     = gnt_sel;
        ptr_d     = gnt_sel;
        tx_d      = gnt_byte;
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: if (acc_done) begin
        cnt_d   = CW'(START_WAIT);
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // SPSR still reads idle while the bridge starts up; don't look yet.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_POLL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_POLL: if (acc_done) begin
        if (!wb.wb_data_in[0]) begin
          state_d = S_RD_DATA;
        end else if (cnt_q + CW'(1) == CW'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_DATA: if (acc_done) begin
        rdat_d  = wb.wb_data_in;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = ONE << sel_q;
        cnt_d     = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_INIT_WR;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state_q <= S_INIT_WR;
      cyc_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ - 1);
      sel_q   <= '0;
      tx_q    <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign wb.wb_cyc      = cyc_q;
  assign wb.wb_stb      = cyc_q;
  assign wb.wb_addr     = addr_q;
  assign wb.wb_we       = we_q;
  assign wb.wb_data_out = dout_q;
  assign rsp_data       = rdat_q;
  assign rsp_err        = err_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_spi_xfer_sched.sv
module tb_spi_xfer_sched;
  localparam int NREQ = 4, START_WAIT = 4, TIMEOUT = 8;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [7:0]        cfg_spcr;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready, rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err, busy;

  always #5 wb_clk = ~wb_clk;

  spi_xfer_sched_if wbif();

  spi_xfer_sched #(.NREQ(NREQ), .START_WAIT(START_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .cfg_spcr(cfg_spcr),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .wb(wbif));

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // ---------------- bridge model (loopback SPI) ----------------
  int   busy_len = -1;   // <0: random busy time per transfer
  bit   stuck = 1'b0;    // SPSR bit 0 stuck at 1
  int   busy_ctr;
  logic [7:0] spdr_m;
  always @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wbif.wb_ack     <= 1'b0;
      wbif.wb_data_in <= 8'h00;
      busy_ctr        <= 0;
    end else begin
      if (busy_ctr > 0) busy_ctr <= busy_ctr - 1;
      if (wbif.wb_cyc && wbif.wb_stb && !wbif.wb_ack) begin
        wbif.wb_ack <= 1'b1;
        if (wbif.wb_we) begin
          if (wbif.wb_addr == 2'b10) begin
            spdr_m   <= wbif.wb_data_out;
            busy_ctr <= (busy_len < 0) ? int'($urandom_range(0, 14)) : busy_len;
          end
        end else if (wbif.wb_addr == 2'b01) begin
          wbif.wb_data_in <= {7'($urandom), (stuck || busy_ctr > 0)};
        end else if (wbif.wb_addr == 2'b10) begin
          wbif.wb_data_in <= spdr_m;
        end else begin
          wbif.wb_data_in <= 8'h00;
        end
      end else begin
        wbif.wb_ack <= 1'b0;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int idx; logic [7:0] d; logic e; } exp_t;
  exp_t exp_q[$];
  int   mptr = NREQ - 1;
  bit   in_flight = 1'b0;
  int   rsp_cnt = 0;
  int   gnt_log[$];

  // Rotating priority: first requester after the last one served.
  function automatic int pick(logic [NREQ-1:0] v, int p);
    logic [NREQ-1:0] t;
    for (int k = 1; k <= NREQ; k++) begin
      t = v >> ((p + k) % NREQ);
      if (t[0]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  int   w;
  exp_t e;
  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      exp_q.delete();
      in_flight = 1'b0;
      mptr = NREQ - 1;
    end else begin
      if (in_flight) chk("busy_during_xfer", busy, 1);
      if (req_ready != '0) begin
        w = pick(req_valid, mptr);
        checks++;
        if (in_flight || w < 0 || req_ready != (ONE << w)) begin
          errors++;
          $display("FAIL grant: got req_ready=%b, expected one-hot %0d (in_flight=%0d)",
                   req_ready, w, in_flight);
        end
        if (w >= 0) begin
          mptr = w;
          e.idx = w;
          e.e = stuck;
          e.d = stuck ? 8'h00 : 8'(req_data >> (8 * w));
          exp_q.push_back(e);
          gnt_log.push_back(w);
        end
        in_flight = 1'b1;
      end
      if (rsp_valid != '0) begin
        rsp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", rsp_valid);
        end else begin
          e = exp_q.pop_front();
          if (rsp_valid != (ONE << e.idx) || rsp_data !== e.d || rsp_err !== e.e) begin
            errors++;
            $display("FAIL rsp: got valid=%b data=%h err=%b, expected req %0d data=%h err=%b",
                     rsp_valid, rsp_data, rsp_err, e.idx, e.d, e.e);
          end
        end
        in_flight = 1'b0;
      end
    end
  end

  // ---------------- Wishbone protocol monitor ----------------
  typedef struct { logic [1:0] a; logic w; logic [7:0] d; } acc_t;
  acc_t acc_log[$];
  acc_t ac;
  int   spsr_reads = 0;
  int   since_spdr = -1;
  logic p_cyc, p_ack, p_we;
  logic [1:0] p_addr;
  logic [7:0] p_dout;
  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      p_cyc = 1'b0; p_ack = 1'b0; since_spdr = -1;
    end else begin
      chk("stb_eq_cyc", wbif.wb_stb, wbif.wb_cyc);
      if (p_cyc && !p_ack)
        chk("held_until_ack", {wbif.wb_cyc, wbif.wb_addr, wbif.wb_we, wbif.wb_data_out},
            {1'b1, p_addr, p_we, p_dout});
      if (p_cyc && p_ack) chk("cyc_low_after_ack", wbif.wb_cyc, 0);
      if (wbif.wb_cyc && !p_cyc && since_spdr >= 0) begin
        chk("start_wait_gap", since_spdr >= START_WAIT, 1);
        since_spdr = -1;
      end else if (!wbif.wb_cyc && since_spdr >= 0) begin
        since_spdr++;
      end
      if (wbif.wb_cyc && wbif.wb_ack) begin
        ac.a = wbif.wb_addr;
        ac.w = wbif.wb_we;
        ac.d = wbif.wb_we ? wbif.wb_data_out : wbif.wb_data_in;
        acc_log.push_back(ac);
        if (wbif.wb_we && wbif.wb_addr == 2'b10) since_spdr = 0;
        if (!wbif.wb_we && wbif.wb_addr == 2'b01) spsr_reads++;
      end
      p_cyc = wbif.wb_cyc; p_ack = wbif.wb_ack; p_we = wbif.wb_we;
      p_addr = wbif.wb_addr; p_dout = wbif.wb_data_out;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(int i, logic [7:0] b, output int lat);
    req_data[i*8 +: 8] = b;
    req_valid[i] = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge wb_clk);
      if (req_ready[i]) break;
      lat++;
      if (lat > 3000) begin
        checks++; errors++;
        $display("FAIL grant_timeout: requester %0d not granted, expected grant", i);
        break;
      end
    end
    @(posedge wb_clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(int target);
    int n = 0;
    while (rsp_cnt < target && n < 4000) begin
      @(posedge wb_clk); n++;
    end
    chk("rsp_arrived", rsp_cnt >= target, 1);
  endtask

  task automatic do_reset();
    wb_rst = 1'b0;
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b1;
  endtask

  int lat, l0, l1, l2, l3, base, snap, n;
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    wb_rst = 1'b0; req_valid = '0; req_data = '0; cfg_spcr = 8'h5A;
    repeat (2) @(posedge wb_clk); #1;
    chk("reset_outs", {wbif.wb_cyc, wbif.wb_stb, wbif.wb_addr, wbif.wb_we, wbif.wb_data_out,
                       req_ready, rsp_valid, rsp_data, rsp_err, busy}, 0);
    acc_log.delete();
    @(posedge wb_clk); #1 wb_rst = 1'b1;
    repeat (20) @(posedge wb_clk); #1;
    chk("init_access_count", acc_log.size(), 1);
    if (acc_log.size() >= 1)
      chk("init_access", {acc_log[0].a, acc_log[0].w, acc_log[0].d}, {2'b00, 1'b1, 8'h5A});
    chk("idle_busy", busy, 0);

    // single loopback transfer
    acc_log.delete(); busy_len = 12; base = rsp_cnt;
    do_req(0, 8'hA5, lat);
    chk("uncontended_latency", lat, 0);
    wait_rsp(base + 1);
    repeat (3) @(posedge wb_clk); #1;
    n = acc_log.size();
    chk("loop_access_count_ok", n >= 4, 1);
    if (n >= 4) begin
      chk("loop_wr_spdr", {acc_log[0].a, acc_log[0].w, acc_log[0].d}, {2'b10, 1'b1, 8'hA5});
      chk("loop_first_spsr", {acc_log[1].a, acc_log[1].w, acc_log[1].d[0]}, {2'b01, 1'b0, 1'b1});
      chk("loop_last_spsr", {acc_log[n-2].a, acc_log[n-2].w, acc_log[n-2].d[0]}, {2'b01, 1'b0, 1'b0});
      chk("loop_rd_spdr", {acc_log[n-1].a, acc_log[n-1].w, acc_log[n-1].d}, {2'b10, 1'b0, 8'hA5});
    end

    // four simultaneous requesters after reset, requester 0 re-requests
    do_reset(); busy_len = -1;
    repeat (20) @(posedge wb_clk); #1;
    gnt_log.delete(); base = rsp_cnt;
    fork
      begin do_req(0, 8'h11, l0); do_req(0, 8'h55, l0); end
      do_req(1, 8'h22, l1);
      do_req(2, 8'h33, l2);
      do_req(3, 8'h44, l3);
    join
    wait_rsp(base + 5);
    chk("rr_grant_count", gnt_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < gnt_log.size()) chk("rr_grant_order", gnt_log[k], rr_exp[k]);

    // randomized contention
    base = rsp_cnt;
    for (int i = 0; i < NREQ; i++) begin
      automatic int ii = i;
      fork
        begin
          int lt;
          for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 20)) @(posedge wb_clk);
            #1 do_req(ii, 8'($urandom), lt);
          end
        end
      join_none
    end
    wait fork;
    wait_rsp(base + 6 * NREQ);

    // SPSR stuck busy -> timeout, then a normal transfer
    repeat (5) @(posedge wb_clk); #1;
    stuck = 1'b1; snap = spsr_reads; base = rsp_cnt;
    do_req(1, 8'h77, lat);
    wait_rsp(base + 1);
    chk("timeout_poll_count", spsr_reads - snap, TIMEOUT);
    stuck = 1'b0;
    do_req(2, 8'h3C, lat);
    wait_rsp(base + 2);

    // reset during POLL aborts; INIT_WR repeats before the next grant
    repeat (5) @(posedge wb_clk); #1;
    busy_len = 40;
    do_req(3, 8'h99, lat);
    n = 0;
    while (!(wbif.wb_cyc && wbif.wb_addr == 2'b01 && !wbif.wb_we && !wbif.wb_ack) && n < 500) begin
      @(posedge wb_clk); #1; n++;
    end
    chk("poll_reached", n < 500, 1);
    #1 wb_rst = 1'b0;
    snap = rsp_cnt;
    acc_log.delete();
    #1 chk("async_cyc_drop", {wbif.wb_cyc, wbif.wb_stb}, 0);
    busy_len = -1;
    fork do_req(2, 8'h42, l2); join_none
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b1;
    wait fork;
    chk("init_before_grant_count", acc_log.size() >= 1, 1);
    if (acc_log.size() >= 1)
      chk("init_before_grant", {acc_log[0].a, acc_log[0].w, acc_log[0].d}, {2'b00, 1'b1, 8'h5A});
    wait_rsp(snap + 1);
    repeat (10) @(posedge wb_clk); #1;
    chk("no_rsp_for_aborted", rsp_cnt, snap + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
